wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Two-master round-robin Wishbone arbiter. It shares one Wishbone slave between two cpu_to_wb-style masters, e.g. two CPU adapters feeding one memory.
- Holds the grant for the whole owner cycle (cyc held high), routes ack/data back only to the owner, and aborts a hung slave access with a watchdog error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- SEL_W, DATA_W/8, byte-select width.
- TIMEOUT, 255, max cycles stb may wait for ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_adr_i  in  ADDR_W  master N address (N = 0, 1; same applies to all mN_ ports below).
- mN_dat_i  in  DATA_W  master N write data.
- mN_dat_o  out  DATA_W  read data to master N.
- mN_we_i  in  1  master N write enable.
- mN_stb_i  in  1  master N strobe.
- mN_sel_i  in  SEL_W  master N byte selects.
- mN_cyc_i  in  1  master N cycle request.
- mN_ack_o  out  1  ack to master N.
- mN_err_o  out  1  watchdog error to master N.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_dat_i  in  DATA_W  slave read data.
- s_we_o  out  1  slave write enable.
- s_stb_o  out  1  slave strobe.
- s_sel_o  out  SEL_W  slave byte selects.
- s_cyc_o  out  1  slave cycle.
- s_ack_i  in  1  slave ack.
- gnt_o  out  2  one-hot current owner; 00 = none.

Behaviour:
- States: IDLE, OWN0, OWN1, ABORT. Registered state plus last_srv (the last master served).
- Reset (sync, overrides everything): state=IDLE, last_srv=1 (so m0 wins the first tie), wd_cnt=0, gnt_o=00.
  - All slave outputs are 0 while IDLE/ABORT. All mN_ack_o, mN_err_o and mN_dat_o are 0.
- IDLE:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master != last_srv.
  - Grant latency: 1 cycle from cyc_i high to s_cyc_o high.
- OWNn:
  - s_adr/dat/we/stb/sel/cyc_o = mN inputs, combinational mux. gnt_o bit n = 1.
  - mN_ack_o = s_ack_i and mN_dat_o = s_dat_i, combinational; this adds no ack latency.
  - Non-owner ack/err/dat_o = 0.
- Owner release:
  - The edge where the owner's cyc_i is sampled low -> IDLE; last_srv=n.
  - Exactly one idle cycle (s_cyc_o=0) always separates two ownerships, even if the other master is waiting.
  - A grant is never pre-empted mid-cycle.
- Watchdog:
  - wd_cnt increments each cycle s_stb_o=1 and s_ack_i=0. It clears when s_ack_i=1 or s_stb_o=0.
  - When wd_cnt reaches TIMEOUT (TIMEOUT>0): one-cycle mN_err_o pulse to the owner that same cycle; next state ABORT; last_srv=n.
  - ack and timeout in the same cycle: ack wins, no err, no abort.
- ABORT:
  - Slave outputs forced 0; gnt_o = 00; owner ack/err = 0.
  - Stay until the aborted master's cyc_i is sampled low, then IDLE.
  - The other master is not granted during ABORT.
- The 8-bit wd_cnt width is sufficient for the default TIMEOUT; the implementation sizes it as $clog2(TIMEOUT+1), minimum 1.
- Reset mid-transfer: slave cyc/stb drop on the reset edge; no ack or err is generated; the grant is lost.
- Slave ack while IDLE/ABORT (spurious): ignored, not forwarded.

Test Plan:
- Single master: m0 holds cyc/stb/we=1, adr=0x10, dat=0xDEADBEEF, sel=0xF; slave acks 2 cycles after s_stb_o -> s_cyc_o rises 1 cycle after m0_cyc_i; s_adr_o=0x10; m0_ack_o same cycle as s_ack_i; m1_ack_o=0 throughout.
- Tie after reset: m0 and m1 raise cyc the same cycle -> gnt_o=01 first. After m0 drops cyc: 1 idle cycle, then gnt_o=10.
  - Repeat the tie -> gnt_o=01 again (alternation).
- Hold/no pre-empt: m1 owns and issues 3 back-to-back reads (s_dat_i=0x1,0x2,0x3) while m0 requests -> gnt_o stays 10 for all 3 acks; m1_dat_o sees 0x1,0x2,0x3; m0_dat_o stays 0.
- Watchdog: TIMEOUT=4, m0 strobes, slave never acks -> m0_err_o pulses 1 cycle at wd_cnt=4; s_cyc_o=0 next cycle; state stays ABORT until m0_cyc_i=0, then IDLE.
  - Variant: ack on the 4th cycle -> no err.
- Reset mid-op: assert reset while OWN1 with s_stb_o=1 -> next edge: s_cyc_o=s_stb_o=0, gnt_o=00.
  - After reset release, both request -> m0 granted.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// -----------------------------------------------------------------------------
// Two-master round-robin Wishbone arbiter. One slave is shared between two
// masters. The grant is held for the owner's whole bus cycle (cyc high). Ack
// and read data go back only to the owner. A watchdog aborts a slave access
// that hangs.
//
// Handshake: a transfer is offered while s_stb_o is high. It completes in the
// cycle where s_ack_i is high. The master keeps stb and its payload stable
// until that cycle. cyc brackets a burst of such transfers, and the grant is
// never taken away while the owner holds cyc.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset
//   mN_adr_i/dat_i/we_i/  master N request (N = 0, 1)
//   stb_i/sel_i/cyc_i
//   mN_dat_o/ack_o/err_o  master N response (err = watchdog abort pulse)
//   s_adr_o/dat_o/we_o/   request muxed to the shared slave
//   stb_o/sel_o/cyc_o
//   s_dat_i/ack_i         slave response
//   gnt_o                 one-hot owner (bit0 = m0, bit1 = m1), 00 = none
//   dbg_state_o           FSM state: 0 IDLE, 1 OWN0, 2 OWN1, 3 ABORT
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic              m0_cyc_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic              m1_cyc_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic              s_we_o,
    output logic              s_stb_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic              s_cyc_o,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o,
    output logic [1:0]        dbg_state_o
);

    // The counter must be able to hold TIMEOUT itself. With the watchdog
    // disabled (TIMEOUT = 0) a 1-bit counter is kept so that the widths stay legal.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_srv;
    logic            w_last_srv_nxt;
    logic [WD_W-1:0] r_wd_cnt;
    logic [WD_W-1:0] w_wd_cnt_nxt;

    logic            w_own0;
    logic            w_own1;
    logic            w_timeout;

    assign w_own0      = (r_state == ST_OWN0);
    assign w_own1      = (r_state == ST_OWN1);
    assign dbg_state_o = r_state;

    // ------------------------------------------------------------------
    // Request mux: the owner's signals pass straight through. In IDLE and
    // ABORT everything toward the slave is held at zero.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        gnt_o   = 2'b00;
        if (w_own0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_stb_o = m0_stb_i;
            s_sel_o = m0_sel_i;
            s_cyc_o = m0_cyc_i;
            gnt_o   = 2'b01;
        end else if (w_own1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_stb_o = m1_stb_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i;
            gnt_o   = 2'b10;
        end
    end

    // Timeout fires only on a strobed, unacknowledged cycle. When ack and
    // timeout land in the same cycle, the ack wins.
    assign w_timeout = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (r_wd_cnt == WD_MAX);

    // ------------------------------------------------------------------
    // Response routing. Only the owner sees ack/err/data. Ack and err are
    // also gated by reset, so a transfer cut off by reset never completes.
    // ------------------------------------------------------------------
    always_comb begin
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_own0) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i && !reset;
            m0_err_o = w_timeout && !reset;
        end else if (w_own1) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i && !reset;
            m1_err_o = w_timeout && !reset;
        end
    end

    // Watchdog: counts strobed cycles that have no ack. It saturates at
    // WD_MAX; the abort that follows drops stb, which clears the counter.
    always_comb begin
        w_wd_cnt_nxt = '0;
        if (s_stb_o && !s_ack_i) begin
            w_wd_cnt_nxt = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Ownership always returns to IDLE for at least
    // one cycle, so back-to-back owners are separated by an idle cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_last_srv_nxt = r_last_srv;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_srv ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (w_timeout) begin
                    w_state_nxt    = ST_ABORT;
                    w_last_srv_nxt = 1'b0;
                end else if (!m0_cyc_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_last_srv_nxt = 1'b0;
                end
            end
            ST_OWN1: begin
                if (w_timeout) begin
                    w_state_nxt    = ST_ABORT;
                    w_last_srv_nxt = 1'b1;
                end else if (!m1_cyc_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_last_srv_nxt = 1'b1;
                end
            end
            ST_ABORT: begin
                // last_srv records the aborted master. Wait until that
                // master lets go of its cycle.
                if (r_last_srv ? !m1_cyc_i : !m0_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_srv <= 1'b1;   // m0 wins the first tie
            r_wd_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_srv <= w_last_srv_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
        end
    end

endmodule
